hazard_scoreboard: RTL and testbench

Parametrised pipeline hazard unit for the 5-stage (F/D/E/M/W) core. It adds a per-register pending-write scoreboard, so producers with any result latency stall dependents exactly as long as needed, and supports N source operands with per-source valid bits. It also produces M/W forwarding selects, PC-write control stalls and flushes, and a saturating stall-cycle counter. It sits beside the datapath and is driven by the D/E/M/W pipeline registers and the controller.

---
 rtl/hazard_pkg.sv | 14 +
 rtl/hazard_fwd_sel.sv | 24 ++
 rtl/hazard_scoreboard.sv | 84 ++++++++
 tb/tb_hazard_scoreboard.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the hazard unit: forwarding selects and default sizing.
package hazard_pkg;
  localparam int HZ_NREG    = 16;
  localparam int HZ_MAX_LAT = 3;
  localparam int HZ_LAT_W   = $clog2(HZ_MAX_LAT + 1);

  typedef logic [HZ_LAT_W-1:0] lat_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_t;
endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding comparator for one Execute-stage source operand; M beats W.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int RA_W   = 4,
  parameter int PC_REG = 15
) (
  input  logic [RA_W-1:0] ra,
  input  logic            ra_v,
  input  logic            reg_write_m,
  input  logic [RA_W-1:0] wa_m,
  input  logic            reg_write_w,
  input  logic [RA_W-1:0] wa_w,
  output fwd_t            fwd
);
  logic live;
  assign live = ra_v && (ra != RA_W'(PC_REG));

  always_comb begin
    fwd = FWD_RF;
    if (live && reg_write_m && (wa_m == ra))      fwd = FWD_M;
    else if (live && reg_write_w && (wa_w == ra)) fwd = FWD_W;
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: per-register pending-latency scoreboard, M/W forwarding,
// control-flow stalls/flushes and a saturating stall counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG    = HZ_NREG,
  parameter int RA_W    = $clog2(NREG),
  parameter int NSRC    = 3,
  parameter int MAX_LAT = HZ_MAX_LAT,
  parameter int PC_REG  = 15,
  parameter int PERF_W  = 16,
  localparam int LW     = $clog2(MAX_LAT + 1)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NSRC-1:0][RA_W-1:0] RAD,
  input  logic [NSRC-1:0]           RAD_V,
  input  logic [NSRC-1:0][RA_W-1:0] RAE,
  input  logic [NSRC-1:0]           RAE_V,
  input  logic                      RegWriteD,
  input  logic [RA_W-1:0]           WA3D,
  input  logic [LW-1:0]             LatD,
  input  logic                      RegWriteM,
  input  logic [RA_W-1:0]           WA3M,
  input  logic                      RegWriteW,
  input  logic [RA_W-1:0]           WA3W,
  input  logic                      PCSrcD,
  input  logic                      PCSrcE,
  input  logic                      PCSrcM,
  input  logic                      PCSrcW,
  input  logic                      BranchTakenE,
  output logic [NSRC-1:0][1:0]      ForwardE,
  output logic                      StallF,
  output logic                      StallD,
  output logic                      FlushD,
  output logic                      FlushE,
  output logic [PERF_W-1:0]         StallCnt
);
  logic [NREG-1:0][LW-1:0] pend;
  logic sb_stall, pc_wr_pending, issue;

  always_comb begin
    sb_stall = 1'b0;
    for (int i = 0; i < NSRC; i++)
      if (RAD_V[i] && (RAD[i] != RA_W'(PC_REG)) && (pend[RAD[i]] != '0))
        sb_stall = 1'b1;
  end

  assign pc_wr_pending = PCSrcD | PCSrcE | PCSrcM;
  assign StallF = sb_stall | pc_wr_pending;
  assign StallD = sb_stall;
  assign FlushE = sb_stall | BranchTakenE;
  assign FlushD = pc_wr_pending | PCSrcW | BranchTakenE;
  assign issue  = !StallD && !FlushE;

  // A fresh issue overwrites the count so a younger writer supersedes older ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pend <= '0;
    else
      for (int r = 0; r < NREG; r++)
        if (r == PC_REG)                                      pend[r] <= '0;
        else if (issue && RegWriteD && (WA3D == RA_W'(r)))    pend[r] <= LatD;
        else if (pend[r] != '0)                               pend[r] <= pend[r] - LW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                         StallCnt <= '0;
    else if (StallD && (StallCnt != '1))  StallCnt <= StallCnt + PERF_W'(1);
  end

  for (genvar i = 0; i < NSRC; i++) begin : g_fwd
    fwd_t sel;
    hazard_fwd_sel #(.RA_W(RA_W), .PC_REG(PC_REG)) u_sel (
      .ra         (RAE[i]),
      .ra_v       (RAE_V[i]),
      .reg_write_m(RegWriteM),
      .wa_m       (WA3M),
      .reg_write_w(RegWriteW),
      .wa_w       (WA3W),
      .fwd        (sel)
    );
    assign ForwardE[i] = sel;
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: combinational vector table, then multi-cycle scoreboard sequences.
module tb_hazard_scoreboard;
  logic            clk = 1'b0;
  logic            reset_n;
  logic [2:0][3:0] RAD, RAE;
  logic [2:0]      RAD_V, RAE_V;
  logic            RegWriteD, RegWriteM, RegWriteW;
  logic [3:0]      WA3D, WA3M, WA3W;
  logic [1:0]      LatD;
  logic            PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
  logic [2:0][1:0] ForwardE;
  logic            StallF, StallD, FlushD, FlushE;
  logic [15:0]     StallCnt;

  int n_cmp = 0;
  int n_bad = 0;

  hazard_scoreboard dut (
    .clk(clk), .reset_n(reset_n),
    .RAD(RAD), .RAD_V(RAD_V), .RAE(RAE), .RAE_V(RAE_V),
    .RegWriteD(RegWriteD), .WA3D(WA3D), .LatD(LatD),
    .RegWriteM(RegWriteM), .WA3M(WA3M), .RegWriteW(RegWriteW), .WA3W(WA3W),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE),
    .ForwardE(ForwardE), .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .FlushE(FlushE), .StallCnt(StallCnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0][3:0] rae;
    logic [2:0]      rae_v;
    logic            rwm;
    logic [3:0]      wam;
    logic            rww;
    logic [3:0]      waw;
    logic [3:0]      pc;     // {D,E,M,W}
    logic            bt;
    logic [2:0][1:0] fwd;
    logic            sf, fd, fe;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    RAD = '0; RAD_V = '0; RAE = '0; RAE_V = '0;
    RegWriteD = 0; WA3D = '0; LatD = '0;
    RegWriteM = 0; WA3M = '0; RegWriteW = 0; WA3W = '0;
    {PCSrcD, PCSrcE, PCSrcM, PCSrcW} = '0; BranchTakenE = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    vecs[0]  = '{{4'd0,4'd0,4'd3},   3'b001, 1, 4'd3,  1, 4'd3,  4'b0000, 0, {2'b00,2'b00,2'b10}, 0,0,0};
    vecs[1]  = '{{4'd0,4'd0,4'd3},   3'b001, 1, 4'd4,  1, 4'd3,  4'b0000, 0, {2'b00,2'b00,2'b01}, 0,0,0};
    vecs[2]  = '{{4'd6,4'd5,4'd3},   3'b110, 1, 4'd5,  1, 4'd6,  4'b0000, 0, {2'b01,2'b10,2'b00}, 0,0,0};
    vecs[3]  = '{{4'd15,4'd15,4'd15},3'b111, 1, 4'd15, 1, 4'd15, 4'b0000, 0, {2'b00,2'b00,2'b00}, 0,0,0};
    vecs[4]  = '{{4'd2,4'd2,4'd2},   3'b111, 0, 4'd2,  1, 4'd2,  4'b0000, 0, {2'b01,2'b01,2'b01}, 0,0,0};
    vecs[5]  = '{{4'd0,4'd0,4'd0},   3'b000, 0, 4'd0,  0, 4'd0,  4'b0001, 0, {2'b00,2'b00,2'b00}, 0,1,0};
    vecs[6]  = '{{4'd0,4'd0,4'd0},   3'b000, 0, 4'd0,  0, 4'd0,  4'b0100, 0, {2'b00,2'b00,2'b00}, 1,1,0};
    vecs[7]  = '{{4'd0,4'd0,4'd0},   3'b000, 0, 4'd0,  0, 4'd0,  4'b0000, 1, {2'b00,2'b00,2'b00}, 0,1,1};
    vecs[8]  = '{{4'd0,4'd0,4'd0},   3'b000, 0, 4'd0,  0, 4'd0,  4'b1000, 0, {2'b00,2'b00,2'b00}, 1,1,0};
    vecs[9]  = '{{4'd0,4'd0,4'd0},   3'b001, 1, 4'd0,  0, 4'd0,  4'b0000, 0, {2'b00,2'b00,2'b10}, 0,0,0};
    vecs[10] = '{{4'd0,4'd0,4'd7},   3'b001, 0, 4'd7,  0, 4'd7,  4'b0000, 0, {2'b00,2'b00,2'b00}, 0,0,0};

    idle();
    reset_n = 0;
    #12 reset_n = 1;
    tick();
    chk("rst_cnt", StallCnt, 0);
    chk("rst_stalld", StallD, 0);
    chk("rst_stallf", StallF, 0);
    chk("rst_flush", {FlushD, FlushE}, 0);
    chk("rst_fwd", ForwardE, 0);

    for (int k = 0; k < 11; k++) begin
      idle();
      RAE = vecs[k].rae; RAE_V = vecs[k].rae_v;
      RegWriteM = vecs[k].rwm; WA3M = vecs[k].wam;
      RegWriteW = vecs[k].rww; WA3W = vecs[k].waw;
      {PCSrcD, PCSrcE, PCSrcM, PCSrcW} = vecs[k].pc;
      BranchTakenE = vecs[k].bt;
      #1;
      chk($sformatf("vec%0d_fwd", k), ForwardE, vecs[k].fwd);
      chk($sformatf("vec%0d_sf", k), StallF, vecs[k].sf);
      chk($sformatf("vec%0d_sd", k), StallD, 0);
      chk($sformatf("vec%0d_fd", k), FlushD, vecs[k].fd);
      chk($sformatf("vec%0d_fe", k), FlushE, vecs[k].fe);
      tick();
    end

    // Load to r3: one stall, then forward from W
    idle(); RegWriteD = 1; WA3D = 3; LatD = 1;
    #1 chk("ld_issue_nostall", StallD, 0);
    tick();
    idle(); RAD[0] = 3; RAD_V = 3'b001;
    #1;
    chk("ld_stalld", StallD, 1);
    chk("ld_flushe", FlushE, 1);
    chk("ld_stallf", StallF, 1);
    chk("ld_flushd", FlushD, 0);
    tick();
    chk("ld_stall_over", StallD, 0);
    chk("ld_cnt", StallCnt, 1);
    tick();
    idle(); RAE[0] = 3; RAE_V = 3'b001; RegWriteW = 1; WA3W = 3;
    #1 chk("ld_fwd_w", ForwardE, 6'b000001);

    // ALU to r5: no stall, forward from M
    idle(); RegWriteD = 1; WA3D = 5; LatD = 0;
    tick();
    idle(); RAD[1] = 5; RAD_V = 3'b010;
    #1 chk("alu_nostall", StallD, 0);
    tick();
    idle(); RAE[1] = 5; RAE_V = 3'b010; RegWriteM = 1; WA3M = 5;
    #1 chk("alu_fwd_m", ForwardE, 6'b001000);

    // Latency 3 to r7; all three sources hit it but count once per cycle
    idle(); RegWriteD = 1; WA3D = 7; LatD = 3;
    tick();
    idle(); RAD[0] = 2; RAD_V = 3'b001;
    #1 chk("lat3_unrelated", StallD, 0);
    RAD = {4'd7, 4'd7, 4'd7}; RAD_V = 3'b111;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("lat3_stall%0d", k), StallD, 1);
      tick();
    end
    chk("lat3_released", StallD, 0);
    chk("lat3_cnt", StallCnt, 4);

    // Younger writer with latency 0 supersedes an older latency-3 write
    idle(); RegWriteD = 1; WA3D = 6; LatD = 3;
    tick();
    LatD = 0;
    tick();
    idle(); RAD[0] = 6; RAD_V = 3'b001;
    #1 chk("overwrite_nostall", StallD, 0);

    // Taken branch blocks issue of the D instruction
    idle(); RegWriteD = 1; WA3D = 9; LatD = 2; BranchTakenE = 1;
    #1;
    chk("bt_flushd", FlushD, 1);
    chk("bt_flushe", FlushE, 1);
    chk("bt_stallf", StallF, 0);
    tick();
    idle(); RAD[0] = 9; RAD_V = 3'b001;
    #1 chk("bt_sb_unchanged", StallD, 0);

    // PC write walking D->E->M->W
    for (int k = 0; k < 4; k++) begin
      idle();
      {PCSrcD, PCSrcE, PCSrcM, PCSrcW} = 4'b1000 >> k;
      #1;
      chk($sformatf("pc_stallf%0d", k), StallF, (k < 3) ? 1 : 0);
      chk($sformatf("pc_flushd%0d", k), FlushD, 1);
      tick();
    end
    idle();
    #1 chk("pc_done", {StallF, FlushD}, 0);

    // Invalid / PC_REG sources, then reset during a stall
    idle(); RegWriteD = 1; WA3D = 4; LatD = 2;
    tick();
    idle(); RAD[0] = 4; RAD_V = 3'b000;
    #1 chk("invalid_src", StallD, 0);
    RAD[0] = 15; RAD_V = 3'b001;
    #1 chk("pcreg_src", StallD, 0);
    RAE[0] = 15; RAE_V = 3'b001; RegWriteM = 1; WA3M = 15;
    #1 chk("pcreg_fwd", ForwardE, 0);
    RAD[0] = 4;
    #1 chk("r4_stall", StallD, 1);
    tick();
    chk("r4_cnt", StallCnt, 5);
    chk("r4_still", StallD, 1);
    reset_n = 0;
    #1;
    chk("rst_mid_stalld", StallD, 0);
    chk("rst_mid_cnt", StallCnt, 0);
    tick();
    reset_n = 1;
    tick();
    chk("post_rst_nostall", StallD, 0);
    chk("post_rst_cnt", StallCnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
